// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, iteration count and FSM state type for mul32_shift_add
package mul_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;
endpackage

// File: rtl/fulladder32.sv
// rtl/fulladder32.sv - 32-bit combinational adder stage with carry in/out
module fulladder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Pin,
  output logic [31:0] S,
  output logic        Pout
);

  assign {Pout, S} = {1'b0, A} + {1'b0, B} + {32'b0, Pin};

endmodule

// File: rtl/mul32_shift_add.sv
// rtl/mul32_shift_add.sv - sequential 32x32 unsigned shift-and-add multiplier, one iteration per clock
module mul32_shift_add #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);
  import mul_pkg::*;

  mul_state_t           state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     acc_lo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 c;
  logic [WIDTH-1:0]     acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_d;

  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  fulladder32 u_add (
    .A    (acc_hi_q),
    .B    (add_b),
    .Pin  (1'b0),
    .S    (sum),
    .Pout (c)
  );

  // The adder carry becomes the new MSB, so the 65-bit partial sum never loses a bit.
  assign acc_hi_d = {c, sum[WIDTH-1:1]};
  assign acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= A;
            acc_hi_q <= '0;
            acc_lo_q <= B;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            p_q     <= {acc_hi_d, acc_lo_d};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_mul32_shift_add.sv
// tb/tb_mul32_shift_add.sv - directed self-checking bench for mul32_shift_add
module tb_mul32_shift_add;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] P;

  int n_cmp;
  int n_err;
  int done_cnt;
  int overlap_cnt;

  mul32_shift_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) overlap_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
  endtask

  // Called at the first negedge after the accept edge; i counts edges since accept.
  task automatic wait_done(input bit hold, input int p1, input int p2,
                           output int lat, output int busy_n, output logic [63:0] p_mid);
    lat = -1;
    busy_n = 0;
    p_mid = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      start = hold || (i == p1) || (i == p2);
      busy_n += int'(busy);
      if (i == 16) p_mid = P;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int lat, bn, d0;
    logic [63:0] pm;
    d0 = done_cnt;
    start_op(a, b);
    wait_done(1'b0, -1, -1, lat, bn, pm);
    check_eq({tag, "_latency"}, lat, 32);
    check_eq({tag, "_busy_cycles"}, bn, 32);
    check_eq({tag, "_P"}, P, exp);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse_len"}, done, 0);
    check_eq({tag, "_P_held"}, P, exp);
    check_eq({tag, "_done_count"}, done_cnt - d0 - 1, 0);
  endtask

  initial begin
    int lat, bn, d0;
    logic [63:0] pm;
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    overlap_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_P", P, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("zero", 32'd0, 32'd0, 64'd0);
    run_op("m50x20", 32'd50, 32'd20, 64'd1000);
    run_op("m1995x1996", 32'd1995, 32'd1996, 64'd3982020);
    run_op("m40067x73469", 32'd40067, 32'd73469, 64'd2943682423);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // start pulses while busy must be ignored; operands change after accept
    d0 = done_cnt;
    start_op(32'd7, 32'd6);
    A = 32'd9;
    B = 32'd9;
    wait_done(1'b0, 5, 20, lat, bn, pm);
    check_eq("ignore_latency", lat, 32);
    check_eq("ignore_P", P, 64'd42);
    repeat (3) @(negedge clk);
    check_eq("ignore_done_count", done_cnt - d0, 1);
    check_eq("ignore_idle_busy", busy, 0);
    check_eq("ignore_P_held", P, 64'd42);

    // back-to-back: start held through the DONE cycle
    start_op(32'd3, 32'd4);
    wait_done(1'b1, -1, -1, lat, bn, pm);
    check_eq("b2b_first_latency", lat, 32);
    check_eq("b2b_first_P", P, 64'd12);
    A = 32'd5;
    B = 32'd5;
    @(negedge clk);
    check_eq("b2b_second_busy", busy, 1);
    check_eq("b2b_P_hold_start", P, 64'd12);
    wait_done(1'b0, -1, -1, lat, bn, pm);
    check_eq("b2b_second_latency", lat, 32);
    check_eq("b2b_P_hold_mid", pm, 64'd12);
    check_eq("b2b_second_P", P, 64'd25);
    @(negedge clk);

    // asynchronous reset mid-run
    start_op(32'd123, 32'd456);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_busy_before", busy, 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_P", P, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_P_stays", P, 0);
    run_op("after_reset", 32'd2, 32'd3, 64'd6);

    check_eq("busy_done_overlap", overlap_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
